// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, constants and baud divider helper (used by uart_rx and the transmitter)
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} uart_rx_state_t;
   localparam int UART_DATA_BITS = 8;
   function automatic int baud_div(input int clk_freq, input int baud, input int os);
      int d;
      d = (clk_freq + (baud * os) / 2) / (baud * os);
      return (d < 1) ? 1 : d;
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO
//  clk, rst         clock, synchronous active-high reset (flushes pointers)
//  wr_en_i/wr_data_i write request and data; accepted when not full or when popping in the same cycle
//  rd_en_i          pop head; ignored while empty (a write to an empty FIFO wins)
//  rd_data_o        head entry, forced to 0 while empty
//  empty_o/full_o   occupancy flags
module sync_fifo #(
   parameter int WIDTH     = 8,
   parameter int ADDR_BITS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             empty_o,
   output logic             full_o
);
   logic [WIDTH-1:0]   mem_q [2**ADDR_BITS];
   logic [ADDR_BITS:0] wr_ptr_q, rd_ptr_q;
   logic               do_wr, do_rd;
   always_comb begin
      empty_o   = wr_ptr_q == rd_ptr_q;
      full_o    = (wr_ptr_q[ADDR_BITS] != rd_ptr_q[ADDR_BITS]) &&
                  (wr_ptr_q[ADDR_BITS-1:0] == rd_ptr_q[ADDR_BITS-1:0]);
      do_rd     = rd_en_i && !empty_o;
      do_wr     = wr_en_i && (!full_o || rd_en_i);
      rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[ADDR_BITS-1:0]];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + {{ADDR_BITS{1'b0}}, do_wr};
         rd_ptr_q <= rd_ptr_q + {{ADDR_BITS{1'b0}}, do_rd};
      end
   end
   always_ff @(posedge clk)
      if (do_wr) mem_q[wr_ptr_q[ADDR_BITS-1:0]] <= wr_data_i;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 16x oversampling, mid-bit sampling and a show-ahead byte FIFO
//  clk, rst      clock, synchronous active-high reset
//  rx_i          asynchronous serial line, idles high
//  rd_en_i       pop the head byte (ignored while empty)
//  data_o        FIFO head byte, 0 while empty
//  fifo_empty_o  FIFO empty
//  fifo_full_o   FIFO full
//  frame_err_o   1-cycle pulse: stop bit sampled low
//  overrun_o     1-cycle pulse: good byte dropped because the FIFO was full
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ       = 125_000_000,
   parameter int BAUD           = 115_200,
   parameter int OVERSAMPLE     = 16,
   parameter int FIFO_ADDR_BITS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   input  logic       rd_en_i,
   output logic [7:0] data_o,
   output logic       fifo_empty_o,
   output logic       fifo_full_o,
   output logic       frame_err_o,
   output logic       overrun_o
);
   localparam int DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int TW  = $clog2(OVERSAMPLE);
   uart_rx_state_t          state_q, state_d;
   logic                    rx_meta_q, rx_s_q;
   logic [DW-1:0]           div_q;
   logic [TW-1:0]           tick_q, tick_d;
   logic [2:0]              idx_q, idx_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic                    wr_q, wr_d, ferr_q, ferr_d, ovr_q;
   logic                    tick, div_clr, half, last, full;
   assign tick    = div_q == DW'(DIV - 1);
   // Restart the divider on the start edge so sample points are measured from it
   assign div_clr = (state_q == IDLE) && !rx_s_q;
   assign half    = tick_q == TW'(OVERSAMPLE / 2 - 1);
   assign last    = tick_q == TW'(OVERSAMPLE - 1);
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      wr_d    = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            tick_d  = '0;
            state_d = rx_s_q ? IDLE : START;
         end
         START: if (tick) begin
            tick_d  = half ? '0 : tick_q + 1'b1;
            idx_d   = half ? 3'd0 : idx_q;
            state_d = !half ? START : rx_s_q ? IDLE : DATA;
         end
         DATA: if (tick) begin
            tick_d = last ? '0 : tick_q + 1'b1;
            if (last) begin
               // Shift in from the top so the first (LSB) bit ends up at bit 0
               shift_d = {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
               idx_d   = idx_q + 1'b1;
               state_d = (idx_q == 3'(UART_DATA_BITS - 1)) ? STOP : DATA;
            end
         end
         STOP: if (tick) begin
            tick_d  = last ? '0 : tick_q + 1'b1;
            wr_d    = last && rx_s_q;
            ferr_d  = last && !rx_s_q;
            state_d = !last ? STOP : rx_s_q ? IDLE : WAIT_IDLE;
         end
         WAIT_IDLE: state_d = rx_s_q ? IDLE : WAIT_IDLE;
         default:   state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         div_q     <= '0;
         state_q   <= IDLE;
         tick_q    <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         wr_q      <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         rx_meta_q <= rx_i;
         rx_s_q    <= rx_meta_q;
         div_q     <= (div_clr || tick) ? '0 : div_q + 1'b1;
         state_q   <= state_d;
         tick_q    <= tick_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         wr_q      <= wr_d;
         ferr_q    <= ferr_d;
         ovr_q     <= wr_q && full && !rd_en_i;
      end
   end
   sync_fifo #(.WIDTH(UART_DATA_BITS), .ADDR_BITS(FIFO_ADDR_BITS)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (wr_q),
      .wr_data_i (shift_q),
      .rd_en_i   (rd_en_i),
      .rd_data_o (data_o),
      .empty_o   (fifo_empty_o),
      .full_o    (full)
   );
   assign fifo_full_o = full;
   assign frame_err_o = ferr_q;
   assign overrun_o   = ovr_q;
endmodule
